lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/core_types_pkg.sv | 48 ++++
 rtl/lsu_load_align.sv | 29 ++
 rtl/lsu.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/core_types_pkg.sv
// Shared LSU definitions: FSM state type, RISC-V load/store width codes and
// the byte-lane helpers used when a request is accepted.
package core_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    function automatic logic funct3_illegal(input logic [2:0] funct3, input logic store);
        logic bad;
        case (funct3)
            MEM_B, MEM_H, MEM_W: bad = 1'b0;
            MEM_BU, MEM_HU:      bad = store;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] offset);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << offset;
            2'b01:   be = 4'b0011 << offset;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (funct3[1:0])
            2'b00:   lanes = {4{wdata[7:0]}};
            2'b01:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: shifts the addressed byte/halfword down to
// bit 0 and applies sign or zero extension according to funct3.
module lsu_load_align
    import core_types_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    // Width/sign selection of the shifted word.
    always_comb begin
        o_data = 32'd0;
        case (i_funct3)
            MEM_B:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MEM_H:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MEM_W:   o_data = i_rdata;
            MEM_BU:  o_data = {24'd0, w_shifted[7:0]};
            MEM_HU:  o_data = {16'd0, w_shifted[15:0]};
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding request, IDLE/REQ/WAIT/RESP handshake FSM.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them.
module lsu
    import core_types_pkg::*;
#(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        resp_valid,
    output logic        resp_we,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        resp_misalign,
    output logic        resp_buserr
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(RSP_TIMEOUT - 1);

    lsu_state_t  r_state;
    logic [15:0] r_cnt;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;
    logic [4:0]  r_rd;
    logic        r_req_ready;
    logic        r_dmem_req_valid;
    logic        r_dmem_we;
    logic [3:0]  r_dmem_be;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;
    logic        r_resp_valid;
    logic        r_resp_we;
    logic [31:0] r_resp_data;
    logic        r_resp_misalign;
    logic        r_resp_buserr;

    logic [31:0] w_addr;
    logic        w_misalign;
    logic        w_reject;
    logic [31:0] w_load_data;

    // Effective address and misalignment decision for the incoming request.
    always_comb begin
        w_addr     = req_addr;
        w_misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_funct3[1:0] == 2'b01) begin
            w_misalign = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            w_misalign = (req_addr[1:0] != 2'b00);
        end else begin
            w_misalign = 1'b0;
        end
`else
        case (req_funct3[1:0])
            2'b01:   w_addr[0]   = 1'b0;
            2'b10:   w_addr[1:0] = 2'b00;
            default: w_addr      = req_addr;
        endcase
`endif
    end

    // Illegal width codes are reported through the misalign flag in both builds.
    assign w_reject = w_misalign | funct3_illegal(req_funct3, req_store);

    lsu_load_align u_load_align (
        .i_rdata  (dmem_rdata),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    // Transaction FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_cnt            <= 16'd0;
            r_store          <= 1'b0;
            r_funct3         <= 3'd0;
            r_offset         <= 2'd0;
            r_rd             <= 5'd0;
            r_req_ready      <= 1'b1;
            r_dmem_req_valid <= 1'b0;
            r_dmem_we        <= 1'b0;
            r_dmem_be        <= 4'd0;
            r_dmem_addr      <= 32'd0;
            r_dmem_wdata     <= 32'd0;
            r_resp_valid     <= 1'b0;
            r_resp_we        <= 1'b0;
            r_resp_data      <= 32'd0;
            r_resp_misalign  <= 1'b0;
            r_resp_buserr    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_store      <= req_store;
                        r_funct3     <= req_funct3;
                        r_offset     <= w_addr[1:0];
                        r_rd         <= req_rd;
                        r_req_ready  <= 1'b0;
                        r_dmem_addr  <= {w_addr[31:2], 2'b00};
                        r_dmem_we    <= req_store;
                        r_dmem_be    <= byte_enable(req_funct3, w_addr[1:0]);
                        r_dmem_wdata <= store_lanes(req_funct3, req_wdata);
                        if (w_reject) begin
                            r_state         <= RESP;
                            r_resp_valid    <= 1'b1;
                            r_resp_misalign <= 1'b1;
                        end else begin
                            r_state          <= REQ;
                            r_dmem_req_valid <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        r_dmem_req_valid <= 1'b0;
                        r_cnt            <= 16'd0;
                        r_state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_rsp_valid) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_we    <= ~r_store;
                        r_resp_data  <= r_store ? 32'd0 : w_load_data;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_state       <= RESP;
                        r_resp_valid  <= 1'b1;
                        r_resp_buserr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RESP: begin
                    r_state         <= IDLE;
                    r_req_ready     <= 1'b1;
                    r_resp_valid    <= 1'b0;
                    r_resp_we       <= 1'b0;
                    r_resp_data     <= 32'd0;
                    r_resp_misalign <= 1'b0;
                    r_resp_buserr   <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign dmem_req_valid = r_dmem_req_valid;
    assign dmem_addr      = r_dmem_addr;
    assign dmem_we        = r_dmem_we;
    assign dmem_be        = r_dmem_be;
    assign dmem_wdata     = r_dmem_wdata;
    assign resp_valid     = r_resp_valid;
    assign resp_we        = r_resp_we;
    assign resp_rd        = r_rd;
    assign resp_data      = r_resp_data;
    assign resp_misalign  = r_resp_misalign;
    assign resp_buserr    = r_resp_buserr;

endmodule
